// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state encoding and opcode type for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selector; data side has fixed priority
// unless MEM_ARBITER_RR_EN selects round-robin on instruction/data ties
module mem_arb_pick (
  input  logic i_ic_req,
  input  logic i_dc_rd_req,
  input  logic i_dc_wr_req,
  input  logic i_mask_ic,
  input  logic i_mask_dc,
`ifdef MEM_ARBITER_RR_EN
  input  logic i_last_dc,
`endif
  output logic o_gnt,
  output logic o_gnt_dc,
  output logic o_wr
);
  logic w_ic, w_dc;
  always_comb begin
    w_ic = i_ic_req && !i_mask_ic;
    w_dc = (i_dc_rd_req || i_dc_wr_req) && !i_mask_dc;
`ifdef MEM_ARBITER_RR_EN
    o_gnt_dc = w_dc && (!w_ic || !i_last_dc);
`else
    o_gnt_dc = w_dc;
`endif
    o_gnt = w_ic || w_dc;
    // a pending write-back always beats the data side's own line read
    o_wr = o_gnt_dc && i_dc_wr_req;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data-cache traffic onto one Data_mem port.
// Define MEM_ARBITER_RR_EN for round-robin instead of data-side priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_rd_req,
  input  logic              dc_wr_req,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              busy,
  output logic              m_rden,
  output logic              m_wren,
  output logic [ADDR_W-1:0] m_rd_address,
  output logic [ADDR_W-1:0] m_wr_address,
  output logic [DATA_W-1:0] m_write_data,
  input  logic [DATA_W-1:0] m_read_data
);
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  state_e r_state, w_next;
  op_e r_op;
  logic r_dc, r_mask_ic, r_mask_dc;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_ic_rdata, r_dc_rdata;
  logic [3:0] r_cnt;
  logic w_gnt, w_gnt_dc, w_wr, w_cap;
`ifdef MEM_ARBITER_RR_EN
  logic r_last_dc;
`endif
  mem_arb_pick u_pick (
    .i_ic_req   (ic_req),
    .i_dc_rd_req(dc_rd_req),
    .i_dc_wr_req(dc_wr_req),
    .i_mask_ic  (r_mask_ic),
    .i_mask_dc  (r_mask_dc),
`ifdef MEM_ARBITER_RR_EN
    .i_last_dc  (r_last_dc),
`endif
    .o_gnt      (w_gnt),
    .o_gnt_dc   (w_gnt_dc),
    .o_wr       (w_wr)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_cap = r_state == WAIT && r_cnt == LAT_M1;
    case (r_state)
      IDLE:  w_next = w_gnt ? ISSUE : IDLE;
      ISSUE: w_next = r_op == OP_WR ? RESP : WAIT;
      WAIT:  w_next = w_cap ? RESP : WAIT;
      default: w_next = IDLE;
    endcase
    busy = r_state != IDLE;
    m_rden = r_state == ISSUE && r_op == OP_RD;
    m_wren = r_state == ISSUE && r_op == OP_WR;
    ic_ready = r_state == RESP && !r_dc;
    dc_ready = r_state == RESP && r_dc;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_op <= OP_RD;
      r_dc <= 1'b0;
      r_mask_ic <= 1'b0;
      r_mask_dc <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_ic_rdata <= '0;
      r_dc_rdata <= '0;
      r_cnt <= '0;
`ifdef MEM_ARBITER_RR_EN
      r_last_dc <= 1'b0;
`endif
    end else begin
      // the side just answered sits out the following idle cycle
      r_mask_ic <= r_state == RESP && !r_dc;
      r_mask_dc <= r_state == RESP && r_dc;
      r_cnt <= r_state == WAIT ? r_cnt + 4'd1 : 4'd0;
      if (r_state == IDLE && w_gnt) begin
        r_dc <= w_gnt_dc;
        r_op <= w_wr ? OP_WR : OP_RD;
        r_addr <= w_gnt_dc ? dc_addr : ic_addr;
        r_wdata <= dc_wdata;
`ifdef MEM_ARBITER_RR_EN
        r_last_dc <= w_gnt_dc;
`endif
      end
      if (w_cap && r_dc) r_dc_rdata <= m_read_data;
      if (w_cap && !r_dc) r_ic_rdata <= m_read_data;
    end
  assign m_rd_address = r_addr;
  assign m_wr_address = r_addr;
  assign m_write_data = r_wdata;
  assign ic_rdata = r_ic_rdata;
  assign dc_rdata = r_dc_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_arbiter;
  localparam int LAT = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic ic_req = 1'b0, dc_rd_req = 1'b0, dc_wr_req = 1'b0;
  logic [31:0] ic_addr = '0, dc_addr = '0;
  logic [63:0] dc_wdata = '0;
  logic [63:0] ic_rdata, dc_rdata, m_write_data, m_read_data;
  logic ic_ready, dc_ready, busy, m_rden, m_wren;
  logic [31:0] m_rd_address, m_wr_address;
  int checks = 0, errors = 0, cyc = 0;
  logic [63:0] mem [logic [31:0]];
  logic [63:0] ref_mem [logic [31:0]];
  logic [63:0] pipe [LAT];

  mem_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
    .dc_rd_req(dc_rd_req), .dc_wr_req(dc_wr_req), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_ready(dc_ready), .busy(busy),
    .m_rden(m_rden), .m_wren(m_wren), .m_rd_address(m_rd_address), .m_wr_address(m_wr_address),
    .m_write_data(m_write_data), .m_read_data(m_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_val(input logic [31:0] a);
    return {a ^ 32'h5A5A_0000, ~a};
  endfunction
  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction
  function automatic logic [63:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // memory: data appears exactly LAT cycles after m_rden and only for one cycle
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= m_rden ? mem_rd(m_rd_address) : 64'h0BAD_0BAD_0BAD_0BAD;
    if (m_wren) mem[m_wr_address] = m_write_data;
  end
  assign m_read_data = pipe[LAT-1];

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d expected end", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nr, nops, nrdy, op0, op1, iss_cyc, k3;
    int seq [3];
    logic [63:0] w, exp_ic, exp_dc, dc_w;
    logic ic_pend, dc_rd_p, dc_wr_p, iss_rd;
    logic [31:0] ic_a, dc_a, iss_addr;
    // reset state
    tick; tick;
    chk("rst_busy", busy, 0); chk("rst_rden", m_rden, 0); chk("rst_wren", m_wren, 0);
    chk("rst_ic_ready", ic_ready, 0); chk("rst_dc_ready", dc_ready, 0);
    chk("rst_ic_rdata", ic_rdata, 0); chk("rst_dc_rdata", dc_rdata, 0); chk("rst_addr", m_rd_address, 0);
    rst = 1'b0;
    // lone fetch read: m_rden at T+1, ready at T+4
    mem[32'h100] = 64'hA5A5; ref_mem[32'h100] = 64'hA5A5;
    ic_addr = 32'h100; ic_req = 1'b1;
    tick; chk("rd_rden_T1", m_rden, 1); chk("rd_addr_T1", m_rd_address, 32'h100); chk("rd_busy_T1", busy, 1);
    tick; chk("rd_rden_T2", m_rden, 0);
    tick; chk("rd_ready_T3", ic_ready, 0);
    tick; chk("rd_ready_T4", ic_ready, 1); chk("rd_data", ic_rdata, 64'hA5A5);
    ic_req = 1'b0; exp_ic = 64'hA5A5;
    tick; chk("rd_busy_after", busy, 0); chk("rd_ready_once", ic_ready, 0);
    // three back-to-back ties: dc, ic, dc
    ic_addr = 32'h80; dc_addr = 32'h40; ic_req = 1'b1; dc_rd_req = 1'b1; nr = 0;
    for (int k = 0; k < 40 && nr < 3; k++) begin
      tick;
      if (ic_ready || dc_ready) begin
        seq[nr] = int'(dc_ready);
        if (dc_ready) chk("tie_dc_data", dc_rdata, ref_rd(32'h40));
        else chk("tie_ic_data", ic_rdata, ref_rd(32'h80));
        nr++;
      end
    end
    ic_req = 1'b0; dc_rd_req = 1'b0;
    exp_ic = ref_rd(32'h80); exp_dc = ref_rd(32'h40);
    chk("tie_count", nr, 3); chk("tie_first_dc", seq[0], 1); chk("tie_second_ic", seq[1], 0); chk("tie_third_dc", seq[2], 1);
    tick; tick;
    // lone write-back: ready at T+2
    dc_addr = 32'h200; dc_wdata = 64'h1234; dc_wr_req = 1'b1;
    tick; chk("wr_wren", m_wren, 1); chk("wr_addr", m_wr_address, 32'h200); chk("wr_data", m_write_data, 64'h1234); chk("wr_no_rden", m_rden, 0);
    tick; chk("wr_ready_T2", dc_ready, 1); chk("wr_wren_once", m_wren, 0);
    dc_wr_req = 1'b0; ref_mem[32'h200] = 64'h1234;
    tick; chk("wr_ready_once", dc_ready, 0);
    tick;
    // simultaneous dc read and write: write first, two readies
    w = {$urandom, $urandom}; dc_addr = 32'h48; dc_wdata = w; dc_rd_req = 1'b1; dc_wr_req = 1'b1;
    nops = 0; nrdy = 0; op0 = -1; op1 = -1;
    for (int k = 0; k < 30; k++) begin
      tick;
      if (m_wren || m_rden) begin
        if (nops == 0) op0 = int'(m_wren);
        else if (nops == 1) op1 = int'(m_wren);
        nops++;
      end
      if (dc_ready) begin
        nrdy++;
        if (nrdy == 1) dc_wr_req = 1'b0;
        else begin
          dc_rd_req = 1'b0;
          chk("rw_read_sees_write", dc_rdata, w);
        end
      end
    end
    dc_rd_req = 1'b0; dc_wr_req = 1'b0; ref_mem[32'h48] = w; exp_dc = w;
    chk("rw_ready_count", nrdy, 2); chk("rw_op_count", nops, 2); chk("rw_write_first", op0, 1); chk("rw_read_second", op1, 0);
    // reset while waiting on memory
    ic_addr = 32'h10; ic_req = 1'b1;
    tick; tick; chk("rstw_busy", busy, 1); chk("rstw_in_wait", m_rden, 0);
    #2; rst = 1'b1; ic_req = 1'b0;
    #1;
    chk("rstw_busy0", busy, 0); chk("rstw_rden0", m_rden, 0); chk("rstw_ready0", ic_ready, 0);
    chk("rstw_ic_rdata0", ic_rdata, 0); chk("rstw_dc_rdata0", dc_rdata, 0); chk("rstw_addr0", m_rd_address, 0);
    nr = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      nr += int'(ic_ready || dc_ready);
    end
    chk("rstw_no_ready", nr, 0);
    rst = 1'b0; ic_addr = 32'h300; ic_req = 1'b1;
    tick; chk("rstw_first_edge", m_rden, 1);
    tick; tick; tick; chk("rstw_fresh_ready", ic_ready, 1); chk("rstw_fresh_data", ic_rdata, ref_rd(32'h300));
    ic_req = 1'b0; exp_ic = ref_rd(32'h300); exp_dc = '0;
    tick; tick;
    // request dropped right after grant still completes
    ic_addr = 32'h88; ic_req = 1'b1;
    tick; chk("drop_granted", m_rden, 1);
    ic_req = 1'b0; nr = 0;
    for (int k = 2; k <= 8; k++) begin
      tick;
      if (k == 3) chk("drop_busy_mid", busy, 1);
      if (k == 4) chk("drop_ready", ic_ready, 1);
      if (k == 5) chk("drop_busy_fall", busy, 0);
      nr += int'(ic_ready);
    end
    chk("drop_ready_once", nr, 1); chk("drop_data", ic_rdata, ref_rd(32'h88));
    exp_ic = ref_rd(32'h88);
    // randomized traffic against the transaction model
    ic_pend = 1'b0; dc_rd_p = 1'b0; dc_wr_p = 1'b0; iss_cyc = 0; iss_rd = 1'b0; iss_addr = '0;
    ic_a = '0; dc_a = '0; dc_w = '0;
    for (int n = 0; n < 3000; n++) begin
      tick;
      chk("mutex", int'($countones({m_rden, m_wren, ic_ready, dc_ready}) <= 1), 1);
      if (m_rden || m_wren) begin
        chk("busy_issue", busy, 1);
        iss_cyc = cyc; iss_rd = m_rden; iss_addr = m_rden ? m_rd_address : m_wr_address;
        if (m_wren) begin
          chk("rnd_wr_pending", dc_wr_p, 1); chk("rnd_wr_addr", m_wr_address, dc_a); chk("rnd_wr_data", m_write_data, dc_w);
        end
      end
      if (ic_ready) begin
        chk("rnd_ic_pending", ic_pend, 1); chk("rnd_ic_op", iss_rd, 1); chk("rnd_ic_addr", iss_addr, ic_a);
        chk("rnd_ic_lat", cyc - iss_cyc, LAT + 1);
        exp_ic = ref_rd(ic_a); ic_pend = 1'b0; ic_req = 1'b0;
      end
      if (dc_ready) begin
        if (dc_wr_p) begin
          chk("rnd_dc_write_first", iss_rd, 0); chk("rnd_dc_wr_lat", cyc - iss_cyc, 1);
          ref_mem[dc_a] = dc_w; dc_wr_p = 1'b0; dc_wr_req = 1'b0;
        end else begin
          chk("rnd_dc_rd_op", iss_rd, 1); chk("rnd_dc_rd_addr", iss_addr, dc_a); chk("rnd_dc_rd_lat", cyc - iss_cyc, LAT + 1);
          exp_dc = ref_rd(dc_a); dc_rd_p = 1'b0; dc_rd_req = 1'b0;
        end
      end
      chk("rnd_ic_rdata", ic_rdata, exp_ic);
      chk("rnd_dc_rdata", dc_rdata, exp_dc);
      if (n < 2800 && !ic_pend && $urandom_range(0, 2) == 0) begin
        ic_a = 32'($urandom_range(0, 7) * 8); ic_addr = ic_a; ic_pend = 1'b1; ic_req = 1'b1;
      end
      if (n < 2800 && !dc_rd_p && !dc_wr_p && $urandom_range(0, 2) == 0) begin
        k3 = int'($urandom_range(1, 3));
        dc_a = 32'($urandom_range(0, 7) * 8); dc_w = {$urandom, $urandom};
        dc_rd_p = k3[0]; dc_wr_p = k3[1];
        dc_addr = dc_a; dc_wdata = dc_w; dc_rd_req = dc_rd_p; dc_wr_req = dc_wr_p;
      end
    end
    chk("rnd_drained", {ic_pend, dc_rd_p, dc_wr_p}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
